uart_rx_core: RTL and testbench

Parametrised UART receiver: recovers asynchronous serial frames from the `rx` pin and presents each received word as a single-cycle `data_valid` strike with per-frame parity and framing error flags. It has configurable bit period, data width, parity mode and stop-bit count. It adds an input synchroniser and 3-sample majority voting, and it rejects false start bits. It sits between the board serial pin and any byte consumer (command decoder, FIFO) in the FPGA library.

---
 rtl/uart_rx_core.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receiver with input synchroniser, 3-sample majority voting and
// false-start rejection; one-cycle data_valid strike per completed frame.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int BW   = 4;

  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] C_S1   = CW'(HALF);
  localparam logic [CW-1:0] C_S2   = CW'(HALF + 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  localparam logic [BW-1:0] B_DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_SLAST = BW'(STOP_BITS - 1);
  localparam logic          ODD     = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [1:0]             smp_q, smp_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [DATA_BITS-1:0]   dout_q;
  logic                   dv_q, pe_q, fe_q;

  logic rxs, fall, wrap, decide, maj, exp_par, done;

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign fall    = prev_q & ~rxs;
  assign wrap    = (cnt_q == C_LAST);
  assign decide  = (cnt_q == C_S2);
  assign maj     = (smp_q[0] & smp_q[1])
                 | (smp_q[0] & rxs)
                 | (smp_q[1] & rxs);
  assign exp_par = (^sh_q) ^ ODD;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + C_ONE;
      if (cnt_q == C_S0) smp_d[0] = rxs;
      if (cnt_q == C_S1) smp_d[1] = rxs;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = S_START;
          cnt_d   = C_ONE;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (decide && maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (wrap) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (decide) sh_d = {maj, sh_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_q == B_DLAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (decide && (maj != exp_par)) perr_d = 1'b1;
        if (wrap) state_d = S_STOP;
      end
      S_STOP: begin
        if (decide) begin
          if (!maj) ferr_d = 1'b1;
          // Leave at mid-bit so a start edge half a bit later is seen
          if (bit_q == B_SLAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done    = 1'b1;
          end
        end else if (wrap) begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      prev_q  <= rxs;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      sh_q    <= sh_d;
      perr_q  <= done ? 1'b0 : perr_d;
      ferr_q  <= done ? 1'b0 : ferr_d;
      dv_q    <= done;
      pe_q    <= done & perr_d;
      fe_q    <= done & ferr_d;
      if (done) dout_q <= sh_q;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: 8N1, 8E1 and 7O2 receivers side by side,
// vector table plus false-start, held-low line and mid-frame reset sequences.
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx_v = 3'b111;
  logic [7:0] do_a, do_b;
  logic [6:0] do_c;
  wire  [2:0] dv, pe, fe, bz;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  int stray = 0;
  int pulses[3];
  int dvcyc[3];
  logic [8:0] got_d[3];
  logic got_pe[3];
  logic got_fe[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_v[0]), .data_out(do_a),
    .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0]),
    .busy(bz[0]));

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_v[1]), .data_out(do_b),
    .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1]),
    .busy(bz[1]));

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .SYNC_STAGES(2)) dut_c (
    .clk(clk), .rst(rst), .rx(rx_v[2]), .data_out(do_c),
    .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]),
    .busy(bz[2]));

  function automatic logic [8:0] dout(int u);
    case (u)
      0:       return {1'b0, do_a};
      1:       return {1'b0, do_b};
      default: return {2'b00, do_c};
    endcase
  endfunction

  function automatic int dbits(int u);
    return (u == 2) ? 7 : 8;
  endfunction

  function automatic int nstop(int u);
    return (u == 2) ? 2 : 1;
  endfunction

  initial begin
    for (int u = 0; u < 3; u++) begin
      pulses[u] = 0;
      dvcyc[u]  = 0;
      got_d[u]  = '0;
      got_pe[u] = 1'b0;
      got_fe[u] = 1'b0;
    end
  end

  // Captures every strike; error flags outside a strike, or busy during one, are stray
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (dv[u]) begin
        pulses[u]++;
        dvcyc[u]  = cyc;
        got_d[u]  = dout(u);
        got_pe[u] = pe[u];
        got_fe[u] = fe[u];
        if (bz[u]) stray++;
      end else if (pe[u] || fe[u]) begin
        stray++;
      end
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic send(input int u, input logic [8:0] d, input logic par,
                      input logic [1:0] stp, input int glitch,
                      input bit keep_low, output int s);
    logic bits[12];
    logic v;
    int   n;
    s = 0;
    for (int i = 0; i < 12; i++) bits[i] = 1'b1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < dbits(u); i++) begin
      bits[n] = d[i];
      n++;
    end
    if (u != 0) begin
      bits[n] = par;
      n++;
    end
    for (int i = 0; i < nstop(u); i++) begin
      bits[n] = ~stp[i];
      n++;
    end
    for (int k = 0; k < n * CPB; k++) begin
      @(negedge clk);
      if (k == 0) s = cyc;
      v = bits[k / CPB];
      if (k == glitch) v = ~v;
      rx_v[u] = v;
    end
    if (!keep_low) begin
      @(negedge clk);
      rx_v[u] = 1'b1;
    end
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input int u, input int p0,
                             input int s, input logic [8:0] ed,
                             input logic ep, input logic ef, input int lat);
    check({nm, "_pulses"}, pulses[u] - p0, 1);
    check({nm, "_data"}, got_d[u], ed);
    check({nm, "_perr"}, got_pe[u], ep);
    check({nm, "_ferr"}, got_fe[u], ef);
    check({nm, "_lat"}, dvcyc[u] - s, lat);
    check({nm, "_busy"}, bz[u], 0);
  endtask

  typedef struct {
    int         u;
    logic [8:0] d;
    logic       par;
    logic [1:0] stp;
    int         gl;
    logic [8:0] ed;
    logic       ep;
    logic       ef;
    int         lat;
  } vec_t;

  vec_t tv[9];

  initial begin
    int s, p0, rise_c, fall_c;

    tv[0] = '{0, 9'h03C, 1'b0, 2'b00, -1, 9'h03C, 1'b0, 1'b0, 156};
    tv[1] = '{0, 9'h0A5, 1'b0, 2'b00, -1, 9'h0A5, 1'b0, 1'b0, 156};
    tv[2] = '{1, 9'h037, 1'b1, 2'b00, -1, 9'h037, 1'b0, 1'b0, 172};
    tv[3] = '{1, 9'h037, 1'b0, 2'b00, -1, 9'h037, 1'b1, 1'b0, 172};
    tv[4] = '{0, 9'h000, 1'b0, 2'b00, 56, 9'h000, 1'b0, 1'b0, 156};
    tv[5] = '{2, 9'h02B, 1'b1, 2'b00, -1, 9'h02B, 1'b0, 1'b0, 172};
    tv[6] = '{2, 9'h055, 1'b1, 2'b10, -1, 9'h055, 1'b0, 1'b1, 172};
    tv[7] = '{2, 9'h02B, 1'b0, 2'b00, -1, 9'h02B, 1'b1, 1'b0, 172};
    tv[8] = '{1, 9'h000, 1'b1, 2'b01, -1, 9'h000, 1'b1, 1'b1, 172};

    repeat (3) @(negedge clk);
    check("rst_data_a", do_a, 0);
    check("rst_data_c", do_c, 0);
    check("rst_flags", {dv, pe, fe, bz}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // False start: 4 low cycles, then high
    p0 = pulses[0];
    rise_c = -1;
    fall_c = -1;
    @(negedge clk);
    s = cyc;
    rx_v[0] = 1'b0;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (k == 4) rx_v[0] = 1'b1;
      if (bz[0] && rise_c < 0) rise_c = cyc;
      if (!bz[0] && rise_c >= 0 && fall_c < 0) fall_c = cyc;
    end
    check("fs_rise", rise_c - s, 3);
    check("fs_fall", fall_c - s, 12);
    check("fs_nopulse", pulses[0] - p0, 0);

    for (int i = 0; i < 9; i++) begin
      p0 = pulses[tv[i].u];
      send(tv[i].u, tv[i].d, tv[i].par, tv[i].stp, tv[i].gl, 1'b0, s);
      check_frame($sformatf("vec%0d", i), tv[i].u, p0, s,
                  tv[i].ed, tv[i].ep, tv[i].ef, tv[i].lat);
    end

    // Stop bit low and the line left low afterwards
    p0 = pulses[0];
    send(0, 9'h081, 1'b0, 2'b01, -1, 1'b1, s);
    check_frame("brk", 0, p0, s, 9'h081, 1'b0, 1'b1, 156);
    repeat (60) @(negedge clk);
    check("brk_hold_nopulse", pulses[0] - p0, 1);
    check("brk_hold_busy", bz[0], 0);
    rx_v[0] = 1'b1;
    repeat (20) @(negedge clk);
    p0 = pulses[0];
    send(0, 9'h042, 1'b0, 2'b00, -1, 1'b0, s);
    check_frame("brk_next", 0, p0, s, 9'h042, 1'b0, 1'b0, 156);

    // Mid-frame reset, 8N1
    p0 = pulses[0];
    fork
      begin
        int sd;
        send(0, 9'h0FF, 1'b0, 2'b00, -1, 1'b0, sd);
      end
      begin
        repeat (72) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstA_data", do_a, 0);
        check("rstA_busy", bz[0], 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
      end
    join
    check("rstA_nopulse", pulses[0] - p0, 0);
    send(0, 9'h05A, 1'b0, 2'b00, -1, 1'b0, s);
    check_frame("rstA_next", 0, p0, s, 9'h05A, 1'b0, 1'b0, 156);

    // Mid-frame reset, 7O2
    p0 = pulses[2];
    fork
      begin
        int sd;
        send(2, 9'h07F, 1'b1, 2'b00, -1, 1'b0, sd);
      end
      begin
        repeat (72) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstC_data", do_c, 0);
        check("rstC_busy", bz[2], 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
      end
    join
    check("rstC_nopulse", pulses[2] - p0, 0);
    send(2, 9'h02B, 1'b1, 2'b00, -1, 1'b0, s);
    check_frame("rstC_next", 2, p0, s, 9'h02B, 1'b0, 1'b0, 172);

    check("stray_flags", stray, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
